// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: shared FSM encoding, scoreboard defaults and decoded-lane layout for the issue stage.
package issue_ctrl_pkg;

    localparam logic [0:0] PAIR  = 1'b0;
    localparam logic [0:0] SPLIT = 1'b1;

    localparam int LOAD_LAT_DEF = 2;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       use_rs1;
        logic       use_rs2;
        logic       wr;
        logic       load;
        logic       mem;
        logic       cti;
    } lane_t;

    // x0 is hardwired to zero, so reading it can never depend on an older write
    function automatic logic reads_reg(lane_t l, logic [4:0] r);
        return r != REG_X0 && ((l.use_rs1 && l.rs1 == r) || (l.use_rs2 && l.rs2 == r));
    endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// issue_ctrl_if: decoded pair from the decode->issue register and the issue/stall decisions back.
interface issue_ctrl_if;
    import issue_ctrl_pkg::*;

    logic  pair_valid;
    logic  valid1;
    logic  flush;
    lane_t lane0;
    lane_t lane1;
    logic  issue0;
    logic  issue1;
    logic  stall;

    modport master (
        output pair_valid, valid1, flush, lane0, lane1,
        input  issue0, issue1, stall
    );

    modport slave (
        input  pair_valid, valid1, flush, lane0, lane1,
        output issue0, issue1, stall
    );

endinterface

// File: rtl/issue_ctrl_scoreboard.sv
// issue_scoreboard: per-register countdown of in-flight load latency with six busy lookups.
module issue_scoreboard
    import issue_ctrl_pkg::*;
#(
    parameter int LOAD_LAT = LOAD_LAT_DEF
) (
    input  logic       clock_i,
    input  logic       reset_ni,
    input  logic [4:0] rd_addr [6],
    output logic [5:0] busy,
    input  logic [1:0] set_en,
    input  logic [4:0] set_rd [2]
);

    localparam logic [1:0] SET_VAL = 2'(LOAD_LAT - 1);

    logic [1:0] cnt [32];

    always_comb begin
        busy = '0;
        for (int i = 0; i < 6; i++)
            busy[i] = rd_addr[i] != REG_X0 && cnt[rd_addr[i]] != 2'd0;
    end

    // a fresh load result overrides the countdown of an older one to the same register
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            for (int i = 0; i < 32; i++)
                cnt[i] <= 2'd0;
        end else begin
            for (int i = 0; i < 32; i++)
                cnt[i] <= (i != 0 && ((set_en[0] && set_rd[0] == i[4:0]) || (set_en[1] && set_rd[1] == i[4:0]))) ? SET_VAL
                        : cnt[i] != 2'd0 ? cnt[i] - 2'd1 : cnt[i];
        end
    end

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: dual-issue scheduler; splits conflicting pairs over two cycles and honours load latency.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int LOAD_LAT = LOAD_LAT_DEF
) (
    input  logic         clock_i,
    input  logic         reset_ni,
    issue_ctrl_if.slave  bus
);

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [4:0] rd_addr [6];
    logic [4:0] set_rd [2];
    logic [5:0] busy;
    logic [1:0] set_en;
    logic       haz0;
    logic       haz1;
    logic       raw;
    logic       waw;
    logic       pair_split;
    logic       in_pair;
    logic       in_split;
    logic       go0;
    logic       go1;
    logic       stall;

    always_comb begin
        rd_addr[0] = bus.lane0.rs1;
        rd_addr[1] = bus.lane0.rs2;
        rd_addr[2] = bus.lane0.rd;
        rd_addr[3] = bus.lane1.rs1;
        rd_addr[4] = bus.lane1.rs2;
        rd_addr[5] = bus.lane1.rd;
        set_rd[0]  = bus.lane0.rd;
        set_rd[1]  = bus.lane1.rd;
    end

    issue_scoreboard #(.LOAD_LAT(LOAD_LAT)) u_sb (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .rd_addr  (rd_addr),
        .busy     (busy),
        .set_en   (set_en),
        .set_rd   (set_rd)
    );

    assign haz0 = (bus.lane0.use_rs1 && busy[0]) || (bus.lane0.use_rs2 && busy[1]) || (bus.lane0.wr && busy[2]);
    assign haz1 = (bus.lane1.use_rs1 && busy[3]) || (bus.lane1.use_rs2 && busy[4]) || (bus.lane1.wr && busy[5]);

    assign raw = bus.lane0.wr && reads_reg(bus.lane1, bus.lane0.rd);
    assign waw = bus.lane0.wr && bus.lane1.wr && bus.lane0.rd != REG_X0 && bus.lane0.rd == bus.lane1.rd;
    assign pair_split = raw || waw || (bus.lane0.mem && bus.lane1.mem) || bus.lane0.cti;

    // reset and flush silence every decision below through these two qualifiers
    assign in_pair  = reset_ni && !bus.flush && state == PAIR && bus.pair_valid;
    assign in_split = reset_ni && !bus.flush && state == SPLIT;

    assign go0   = in_pair && !haz0;
    assign go1   = (go0 && bus.valid1 && !haz1 && !pair_split) || (in_split && !haz1);
    assign stall = (in_pair && (haz0 || (bus.valid1 && (haz1 || pair_split)))) || (in_split && haz1);

    assign state_nxt = ((go0 && stall) || (in_split && haz1)) ? SPLIT : PAIR;

    assign set_en[0] = go0 && bus.lane0.load && bus.lane0.wr && bus.lane0.rd != REG_X0;
    assign set_en[1] = go1 && bus.lane1.load && bus.lane1.wr && bus.lane1.rd != REG_X0;

    assign bus.issue0 = go0;
    assign bus.issue1 = go1;
    assign bus.stall  = stall;

    always_ff @(posedge clock_i) begin
        if (!reset_ni)
            state <= PAIR;
        else
            state <= state_nxt;
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed scenarios plus randomized pairs against a timestamp model, for LOAD_LAT 1..3.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pv;
    logic       v1;
    logic       fl;
    lane_t      l0;
    lane_t      l1;
    logic [2:0] obs [3];
    int         checks = 0;
    int         errors = 0;
    int         ready [3][32];
    bit         spl [3];
    int         cyc;

    always #5 clk = ~clk;

    // instance g has LOAD_LAT = g+1; obs = {issue0, issue1, stall}
    for (genvar g = 0; g < 3; g++) begin : gen_dut
        issue_ctrl_if bus ();
        assign bus.pair_valid = pv;
        assign bus.valid1     = v1;
        assign bus.flush      = fl;
        assign bus.lane0      = l0;
        assign bus.lane1      = l1;
        assign obs[g] = {bus.issue0, bus.issue1, bus.stall};
        issue_ctrl #(.LOAD_LAT(g + 1)) dut (
            .clock_i  (clk),
            .reset_ni (rst_n),
            .bus      (bus)
        );
    end

    function automatic lane_t alu(int rd, int a, int b);
        lane_t l = '0;
        l.rd = 5'(rd); l.rs1 = 5'(a); l.rs2 = 5'(b);
        l.use_rs1 = 1'b1; l.use_rs2 = 1'b1; l.wr = 1'b1;
        return l;
    endfunction

    function automatic lane_t ld(int rd, int a);
        lane_t l = '0;
        l.rd = 5'(rd); l.rs1 = 5'(a);
        l.use_rs1 = 1'b1; l.wr = 1'b1; l.load = 1'b1; l.mem = 1'b1;
        return l;
    endfunction

    function automatic lane_t st(int a, int b);
        lane_t l = '0;
        l.rs1 = 5'(a); l.rs2 = 5'(b);
        l.use_rs1 = 1'b1; l.use_rs2 = 1'b1; l.mem = 1'b1;
        return l;
    endfunction

    function automatic lane_t br(int a, int b);
        lane_t l = '0;
        l.rs1 = 5'(a); l.rs2 = 5'(b);
        l.use_rs1 = 1'b1; l.use_rs2 = 1'b1; l.cti = 1'b1;
        return l;
    endfunction

    function automatic lane_t rnd_lane();
        lane_t l = '0;
        l.rs1 = 5'($urandom_range(0, 7));
        l.rs2 = 5'($urandom_range(0, 7));
        l.rd  = 5'($urandom_range(0, 7));
        l.use_rs1 = 1'($urandom_range(0, 1));
        l.use_rs2 = 1'($urandom_range(0, 1));
        l.load = ($urandom_range(0, 2) == 0);
        l.wr   = l.load || ($urandom_range(0, 3) != 0);
        l.mem  = l.load || ($urandom_range(0, 4) == 0);
        l.cti  = !l.mem && ($urandom_range(0, 7) == 0);
        return l;
    endfunction

    function automatic bit m_busy(int g, logic [4:0] r);
        return r != 5'd0 && ready[g][r] > cyc;
    endfunction

    function automatic bit m_haz(int g, lane_t l);
        return (l.use_rs1 && m_busy(g, l.rs1)) || (l.use_rs2 && m_busy(g, l.rs2)) || (l.wr && m_busy(g, l.rd));
    endfunction

    function automatic bit m_conflict(lane_t a, lane_t b);
        bit dep = a.wr && a.rd != 5'd0 && ((b.use_rs1 && b.rs1 == a.rd) || (b.use_rs2 && b.rs2 == a.rd) || (b.wr && b.rd == a.rd));
        return dep || (a.mem && b.mem) || a.cti;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(logic p, logic v, lane_t a, lane_t b);
        pv = p; v1 = v; l0 = a; l1 = b;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fl = 1'b0;
        set_pair(1'b0, 1'b0, '0, '0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fl = 1'b0;
        set_pair(1'b1, 1'b1, alu(1, 2, 3), alu(2, 4, 5));
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (obs[g] !== 3'b000) begin errors++; $display("FAIL reset_hold lat%0d got %b want 000", g + 1, obs[g]); end
        end
        tick();
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (obs[g] !== 3'b000) begin errors++; $display("FAIL reset_edge lat%0d got %b want 000", g + 1, obs[g]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_pair();
        do_reset();
        set_pair(1'b1, 1'b1, alu(1, 2, 3), alu(2, 4, 5));
        checks++;
        if (obs[1] !== 3'b110) begin errors++; $display("FAIL pair_indep got %b want 110", obs[1]); end
        tick();
        set_pair(1'b1, 1'b1, alu(8, 9, 10), alu(11, 12, 13));
        checks++;
        if (obs[1] !== 3'b110) begin errors++; $display("FAIL pair_again got %b want 110", obs[1]); end
        tick();
        set_pair(1'b0, 1'b1, alu(8, 9, 10), alu(11, 12, 13));
        checks++;
        if (obs[1] !== 3'b000) begin errors++; $display("FAIL pair_invalid got %b want 000", obs[1]); end
        tick();
    endtask

    task automatic test_raw();
        do_reset();
        set_pair(1'b1, 1'b1, alu(3, 1, 2), alu(4, 3, 5));
        checks++;
        if (obs[1] !== 3'b101) begin errors++; $display("FAIL raw_first got %b want 101", obs[1]); end
        tick();
        checks++;
        if (obs[1] !== 3'b010) begin errors++; $display("FAIL raw_second got %b want 010", obs[1]); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_pair(1'b1, 1'b1, ld(5, 1), alu(6, 5, 5));
        checks++;
        if (obs[1] !== 3'b101) begin errors++; $display("FAIL ldu_t0 got %b want 101", obs[1]); end
        tick();
        checks++;
        if (obs[1] !== 3'b001) begin errors++; $display("FAIL ldu_t1 got %b want 001", obs[1]); end
        tick();
        checks++;
        if (obs[1] !== 3'b010) begin errors++; $display("FAIL ldu_t2 got %b want 010", obs[1]); end
        tick();
        do_reset();
        set_pair(1'b1, 1'b0, ld(5, 1), '0);
        tick();
        set_pair(1'b1, 1'b0, alu(6, 5, 5), '0);
        checks++;
        if (obs[0] !== 3'b100) begin errors++; $display("FAIL ldu_lat1 got %b want 100", obs[0]); end
        checks++;
        if (obs[2] !== 3'b001) begin errors++; $display("FAIL ldu_lat3_t1 got %b want 001", obs[2]); end
        tick();
        checks++;
        if (obs[2] !== 3'b001) begin errors++; $display("FAIL ldu_lat3_t2 got %b want 001", obs[2]); end
        tick();
        checks++;
        if (obs[2] !== 3'b100) begin errors++; $display("FAIL ldu_lat3_t3 got %b want 100", obs[2]); end
        tick();
    endtask

    task automatic test_mem_cti();
        do_reset();
        set_pair(1'b1, 1'b1, ld(9, 1), st(2, 3));
        checks++;
        if (obs[1] !== 3'b101) begin errors++; $display("FAIL mem_first got %b want 101", obs[1]); end
        tick();
        checks++;
        if (obs[1] !== 3'b010) begin errors++; $display("FAIL mem_second got %b want 010", obs[1]); end
        tick();
        set_pair(1'b1, 1'b1, br(1, 2), alu(10, 11, 12));
        checks++;
        if (obs[1] !== 3'b101) begin errors++; $display("FAIL cti_first got %b want 101", obs[1]); end
        tick();
        checks++;
        if (obs[1] !== 3'b010) begin errors++; $display("FAIL cti_second got %b want 010", obs[1]); end
        tick();
    endtask

    task automatic test_waw_load();
        do_reset();
        set_pair(1'b1, 1'b0, ld(7, 1), '0);
        checks++;
        if (obs[1] !== 3'b100) begin errors++; $display("FAIL waw_load got %b want 100", obs[1]); end
        tick();
        set_pair(1'b1, 1'b0, alu(7, 2, 3), '0);
        checks++;
        if (obs[1] !== 3'b001) begin errors++; $display("FAIL waw_stall got %b want 001", obs[1]); end
        tick();
        checks++;
        if (obs[1] !== 3'b100) begin errors++; $display("FAIL waw_issue got %b want 100", obs[1]); end
        tick();
    endtask

    task automatic test_flush_split();
        do_reset();
        set_pair(1'b1, 1'b1, alu(3, 1, 2), alu(4, 3, 5));
        tick();
        fl = 1'b1; #1;
        checks++;
        if (obs[1] !== 3'b000) begin errors++; $display("FAIL flush_split got %b want 000", obs[1]); end
        tick();
        fl = 1'b0;
        set_pair(1'b1, 1'b1, alu(1, 2, 3), alu(2, 4, 5));
        checks++;
        if (obs[1] !== 3'b110) begin errors++; $display("FAIL flush_to_pair got %b want 110", obs[1]); end
        tick();
        set_pair(1'b1, 1'b0, ld(7, 1), '0);
        tick();
        fl = 1'b1;
        set_pair(1'b1, 1'b0, alu(8, 7, 7), '0);
        checks++;
        if (obs[1] !== 3'b000) begin errors++; $display("FAIL flush_hazard got %b want 000", obs[1]); end
        tick();
        fl = 1'b0; #1;
        checks++;
        if (obs[1] !== 3'b100) begin errors++; $display("FAIL flush_after got %b want 100", obs[1]); end
        tick();
    endtask

    task automatic test_reset_pending();
        do_reset();
        set_pair(1'b1, 1'b1, ld(7, 1), alu(8, 7, 2));
        tick();
        rst_n = 1'b0; #1;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (obs[g] !== 3'b000) begin errors++; $display("FAIL rst_mid lat%0d got %b want 000", g + 1, obs[g]); end
        end
        tick();
        rst_n = 1'b1;
        set_pair(1'b1, 1'b1, alu(9, 7, 7), alu(10, 1, 2));
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (obs[g] !== 3'b110) begin errors++; $display("FAIL rst_release lat%0d got %b want 110", g + 1, obs[g]); end
        end
        tick();
    endtask

    task automatic test_random();
        logic [2:0] e [3];
        do_reset();
        cyc = 0;
        for (int g = 0; g < 3; g++) begin
            spl[g] = 1'b0;
            for (int r = 0; r < 32; r++) ready[g][r] = 0;
        end
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            fl = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) != 0)
                set_pair(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), rnd_lane(), rnd_lane());
            else
                #1;
            for (int g = 0; g < 3; g++) begin
                e[g] = 3'b000;
                if (rst_n && !fl) begin
                    if (spl[g])
                        e[g] = m_haz(g, l1) ? 3'b001 : 3'b010;
                    else if (pv && m_haz(g, l0))
                        e[g] = 3'b001;
                    else if (pv && !v1)
                        e[g] = 3'b100;
                    else if (pv)
                        e[g] = (m_haz(g, l1) || m_conflict(l0, l1)) ? 3'b101 : 3'b110;
                end
                checks++;
                if (obs[g] !== e[g]) begin errors++; $display("FAIL random n%0d lat%0d got %b want %b", n, g + 1, obs[g], e[g]); end
            end
            tick();
            for (int g = 0; g < 3; g++) begin
                if (!rst_n) begin
                    spl[g] = 1'b0;
                    for (int r = 0; r < 32; r++) ready[g][r] = 0;
                end else begin
                    if (e[g][2] && l0.load && l0.wr && l0.rd != 5'd0) ready[g][l0.rd] = cyc + g + 1;
                    if (e[g][1] && l1.load && l1.wr && l1.rd != 5'd0) ready[g][l1.rd] = cyc + g + 1;
                    spl[g] = e[g][0] && (spl[g] || e[g][2]);
                end
            end
            cyc++;
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_raw();
        test_load_use();
        test_mem_cti();
        test_waw_load();
        test_flush_split();
        test_reset_pending();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
